// File: rtl/mac_operand_feeder.sv
// mac_operand_feeder: buffers operand pairs in a circular FIFO and streams them into a MAC as Clr, N x En, done.
module mac_operand_feeder #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 8
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       wr_en,
   input  logic [DATA_W-1:0]          wr_a,
   input  logic [DATA_W-1:0]          wr_b,
   output logic                       wr_ready,
   input  logic                       start,
   output logic                       En,
   output logic                       Clr,
   output logic [DATA_W-1:0]          Ain,
   output logic [DATA_W-1:0]          Bin,
   output logic                       busy,
   output logic                       done,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH+1)-1:0] count
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);
   typedef enum logic [1:0] {IDLE, CLEAR, STREAM, DONE} state_t;
   state_t state_q, state_d;
   logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
   logic [CW-1:0] count_q, count_d;
   logic en_q, en_d, clr_q, clr_d, done_q, done_d;
   logic [DATA_W-1:0] ain_q, ain_d, bin_q, bin_d;
   logic [2*DATA_W-1:0] mem_q [DEPTH];
   logic push, pop;
   assign full     = count_q == CW'(DEPTH);
   assign empty    = count_q == '0;
   assign wr_ready = state_q == IDLE && !full;
   assign push     = wr_en && wr_ready;
   // CLEAR always pops the first pair so En rises on the cycle right after Clr
   assign pop      = state_q == CLEAR || (state_q == STREAM && !empty);
   assign busy     = state_q != IDLE;
   assign count    = count_q;
   assign En       = en_q;
   assign Clr      = clr_q;
   assign done     = done_q;
   assign Ain      = ain_q;
   assign Bin      = bin_q;
   always_comb begin
      state_d = state_q == IDLE   ? ((start && (!empty || push)) ? CLEAR : IDLE)
              : state_q == CLEAR  ? STREAM
              : state_q == STREAM ? (empty ? DONE : STREAM)
              : IDLE;
      wptr_d  = push ? (wptr_q == PW'(DEPTH-1) ? '0 : wptr_q + 1'b1) : wptr_q;
      rptr_d  = pop ? (rptr_q == PW'(DEPTH-1) ? '0 : rptr_q + 1'b1) : rptr_q;
      count_d = count_q + CW'(push) - CW'(pop);
      en_d    = pop;
      clr_d   = state_d == CLEAR;
      done_d  = state_d == DONE;
      {ain_d, bin_d} = pop ? mem_q[rptr_q] : '0;
   end
   always_ff @(posedge clk) begin
      if (push) mem_q[wptr_q] <= {wr_a, wr_b};
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
         en_q    <= 1'b0;
         clr_q   <= 1'b0;
         done_q  <= 1'b0;
         ain_q   <= '0;
         bin_q   <= '0;
      end else begin
         state_q <= state_d;
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
         en_q    <= en_d;
         clr_q   <= clr_d;
         done_q  <= done_d;
         ain_q   <= ain_d;
         bin_q   <= bin_d;
      end
   end
endmodule

// File: tb/tb_mac_operand_feeder.sv
// tb_mac_operand_feeder: directed and random stimulus checked each cycle against a transaction-level schedule model.
module tb_mac_operand_feeder;
   localparam int DW = 8;
   localparam int DEPTH = 8;
   localparam int CW = $clog2(DEPTH+1);
   logic clk = 1'b0, rst_n = 1'b0, wr_en = 1'b0, start = 1'b0;
   logic [DW-1:0] wr_a = '0, wr_b = '0;
   logic wr_ready, En, Clr, busy, done, full, empty;
   logic [DW-1:0] Ain, Bin;
   logic [CW-1:0] count;
   mac_operand_feeder #(.DATA_W(DW), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_a(wr_a), .wr_b(wr_b),
      .wr_ready(wr_ready), .start(start), .En(En), .Clr(Clr), .Ain(Ain), .Bin(Bin),
      .busy(busy), .done(done), .full(full), .empty(empty), .count(count)
   );
   always #5 clk = ~clk;
   typedef struct packed {logic en; logic clr; logic dn; logic [DW-1:0] a; logic [DW-1:0] b;} ent_t;
   ent_t sched[$];
   logic [2*DW-1:0] fifo[$];
   int errors = 0, checks = 0;
   int unsigned acc = 0, exp_sum = 0;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask
   function automatic ent_t mk(input logic e, input logic c, input logic d, input logic [DW-1:0] a, input logic [DW-1:0] b);
      mk = {e, c, d, a, b};
   endfunction
   // A start accepted in idle schedules the whole transaction: Clr, every buffered pair, done
   task automatic cycle();
      ent_t cur;
      int rem;
      logic [2*DW-1:0] p;
      @(posedge clk);
      if (!rst_n) begin
         fifo.delete();
         sched.delete();
      end else if (sched.size() != 0) begin
         void'(sched.pop_front());
      end else begin
         if (wr_en && fifo.size() < DEPTH) fifo.push_back({wr_a, wr_b});
         if (start && fifo.size() > 0) begin
            sched.push_back(mk(1'b0, 1'b1, 1'b0, '0, '0));
            exp_sum = 0;
            while (fifo.size() != 0) begin
               p = fifo.pop_front();
               sched.push_back(mk(1'b1, 1'b0, 1'b0, p[2*DW-1:DW], p[DW-1:0]));
               exp_sum += int'(p[2*DW-1:DW]) * int'(p[DW-1:0]);
            end
            sched.push_back(mk(1'b0, 1'b0, 1'b1, '0, '0));
         end
      end
      #1;
      cur = sched.size() != 0 ? sched[0] : '0;
      rem = fifo.size();
      for (int i = 1; i < sched.size(); i++) rem += int'(sched[i].en);
      check("en", En, cur.en);
      check("clr", Clr, cur.clr);
      check("done", done, cur.dn);
      check("ain", Ain, cur.a);
      check("bin", Bin, cur.b);
      check("busy", busy, sched.size() != 0);
      check("count", count, rem);
      check("full", full, rem == DEPTH);
      check("empty", empty, rem == 0);
      check("wr_ready", wr_ready, sched.size() == 0 && rem != DEPTH);
      if (Clr) acc = 0;
      else if (En) acc += int'(Ain) * int'(Bin);
      if (cur.dn) check("cout", acc, exp_sum);
   endtask
   task automatic push(input logic [DW-1:0] a, input logic [DW-1:0] b);
      wr_en = 1'b1; wr_a = a; wr_b = b;
      cycle();
      wr_en = 1'b0;
   endtask
   task automatic go();
      start = 1'b1;
      cycle();
      start = 1'b0;
   endtask
   initial begin
      repeat (2) cycle();
      rst_n = 1'b1;
      cycle();
      push(2, 2); push(3, 1); push(1, 5); push(4, 4);
      go();
      repeat (7) cycle();
      check("cout_basic", acc, 28);
      for (int i = 0; i < 9; i++) push(DW'(i + 1), DW'(i + 2));
      check("full_after9", full, 1);
      go();
      repeat (12) cycle();
      go();
      repeat (2) cycle();
      check("empty_start_busy", busy, 0);
      wr_en = 1'b1; wr_a = 5; wr_b = 5; start = 1'b1;
      cycle();
      wr_en = 1'b0; start = 1'b0;
      repeat (4) cycle();
      check("cout_same_edge", acc, 25);
      for (int i = 0; i < 6; i++) push(DW'($urandom), DW'($urandom));
      go();
      repeat (3) cycle();
      rst_n = 1'b0;
      cycle();
      rst_n = 1'b1;
      check("abort_count", count, 0);
      repeat (3) cycle();
      for (int i = 0; i < 3; i++) push(DW'($urandom), DW'($urandom));
      go();
      cycle();
      rst_n = 1'b0; #2; rst_n = 1'b1;
      repeat (6) cycle();
      for (int r = 0; r < 2; r++) begin
         for (int i = 0; i < 7; i++) push(DW'($urandom), DW'($urandom));
         go();
         wr_en = 1'b1;
         for (int i = 0; i < 9; i++) begin
            wr_a = DW'($urandom); wr_b = DW'($urandom);
            cycle();
         end
         wr_en = 1'b0;
         cycle();
      end
      for (int i = 0; i < 1500; i++) begin
         wr_en = $urandom_range(0, 9) < 6;
         wr_a = DW'($urandom); wr_b = DW'($urandom);
         start = $urandom_range(0, 9) == 0;
         rst_n = $urandom_range(0, 99) != 0;
         cycle();
      end
      rst_n = 1'b1; wr_en = 1'b0; start = 1'b0;
      repeat (3) cycle();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
